// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the serial comparator transmit path.
package serial_cmp_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} ser_state_t;

  // Bit presented on the serial line: the word's MSB or LSB depending on order.
  function automatic logic head_bit(input logic [MAX_WIDTH-1:0] word,
                                   input int unsigned           width,
                                   input logic                  msb_first);
    return msb_first ? word[MAX_IDX_W'(width - 1)] : word[0];
  endfunction

endpackage

// File: rtl/serial_pair_hold_buffer.sv
// One-entry holding register for an A/B operand pair with a full flag.
module serial_pair_hold_buffer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             full,
  output logic [WIDTH-1:0] hold_a,
  output logic [WIDTH-1:0] hold_b
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
    end else if (load) begin
      full   <= 1'b1;
      hold_a <= a_word;
      hold_b <= b_word;
    end else if (take) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_pair_serializer.sv
// Parallel-to-serial operand pair transmitter for the serial comparators.
// Optional reference outputs under SERIAL_PAIR_SERIALIZER_REF_EN.
module serial_pair_serializer
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             cmp_clear,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_last
`ifdef SERIAL_PAIR_SERIALIZER_REF_EN
  ,
  output logic             ref_less,
  output logic             ref_eq,
  output logic             ref_greater
`endif
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state, state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] sh_a, sh_b, hold_a, hold_b;
  logic             hold_full, hold_load, hold_take, load_direct;
  logic             xfer, last_bit;

  assign in_ready = (state == IDLE) || !hold_full;
  assign xfer     = in_valid && in_ready;
  assign last_bit = (bit_cnt == LAST_CNT);

  serial_pair_hold_buffer #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (hold_load),
    .take   (hold_take),
    .a_word (a_word),
    .b_word (b_word),
    .full   (hold_full),
    .hold_a (hold_a),
    .hold_b (hold_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cmp_clear   = 1'b0;
    ser_valid   = 1'b0;
    ser_last    = 1'b0;
    hold_load   = 1'b0;
    hold_take   = 1'b0;
    load_direct = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          load_direct = 1'b1;
          state_next  = CLEAR;
        end
      end
      CLEAR: begin
        cmp_clear  = 1'b1;
        hold_load  = xfer;
        state_next = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_last  = last_bit;
        // On the last bit an empty hold lets a new pair bypass straight into the shifter.
        if (!last_bit) begin
          hold_load = xfer;
        end else if (hold_full) begin
          hold_take  = 1'b1;
          state_next = CLEAR;
        end else if (xfer) begin
          load_direct = 1'b1;
          state_next  = CLEAR;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a    <= '0;
      sh_b    <= '0;
      bit_cnt <= '0;
    end else if (load_direct) begin
      sh_a    <= a_word;
      sh_b    <= b_word;
      bit_cnt <= '0;
    end else if (hold_take) begin
      sh_a    <= hold_a;
      sh_b    <= hold_b;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      if (MSB_FIRST) begin
        sh_a <= {sh_a[WIDTH-2:0], 1'b0};
        sh_b <= {sh_b[WIDTH-2:0], 1'b0};
      end else begin
        sh_a <= {1'b0, sh_a[WIDTH-1:1]};
        sh_b <= {1'b0, sh_b[WIDTH-1:1]};
      end
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end else if (state == CLEAR) begin
      bit_cnt <= '0;
    end
  end

  assign ser_a = (state == SHIFT) && head_bit(MAX_WIDTH'(sh_a), WIDTH, MSB_FIRST);
  assign ser_b = (state == SHIFT) && head_bit(MAX_WIDTH'(sh_b), WIDTH, MSB_FIRST);

`ifdef SERIAL_PAIR_SERIALIZER_REF_EN
  logic [WIDTH-1:0] src_a, src_b;

  assign src_a = load_direct ? a_word : hold_a;
  assign src_b = load_direct ? b_word : hold_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_less    <= 1'b0;
      ref_eq      <= 1'b1;
      ref_greater <= 1'b0;
    end else if (load_direct || hold_take) begin
      ref_less    <= (src_a <  src_b);
      ref_eq      <= (src_a == src_b);
      ref_greater <= (src_a >  src_b);
    end
  end
`endif

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Directed bench: MSB-first and LSB-first instances driven in parallel.
module tb_serial_pair_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] a_word = '0;
  logic [15:0] b_word = '0;

  logic in_ready_m, cmp_clear_m, ser_valid_m, ser_a_m, ser_b_m, ser_last_m;
  logic in_ready_l, cmp_clear_l, ser_valid_l, ser_a_l, ser_b_l, ser_last_l;
`ifdef SERIAL_PAIR_SERIALIZER_REF_EN
  logic ref_less_m, ref_eq_m, ref_greater_m;
  logic ref_less_l, ref_eq_l, ref_greater_l;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] cap_ma, cap_mb, cap_la, cap_lb;
  logic [5:0]  sig_m, sig_l;

  always #5 clk = ~clk;

  serial_pair_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .a_word    (a_word),
    .b_word    (b_word),
    .cmp_clear (cmp_clear_m),
    .ser_valid (ser_valid_m),
    .ser_a     (ser_a_m),
    .ser_b     (ser_b_m),
    .ser_last  (ser_last_m)
`ifdef SERIAL_PAIR_SERIALIZER_REF_EN
    ,
    .ref_less    (ref_less_m),
    .ref_eq      (ref_eq_m),
    .ref_greater (ref_greater_m)
`endif
  );

  serial_pair_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .a_word    (a_word),
    .b_word    (b_word),
    .cmp_clear (cmp_clear_l),
    .ser_valid (ser_valid_l),
    .ser_a     (ser_a_l),
    .ser_b     (ser_b_l),
    .ser_last  (ser_last_l)
`ifdef SERIAL_PAIR_SERIALIZER_REF_EN
    ,
    .ref_less    (ref_less_l),
    .ref_eq      (ref_eq_l),
    .ref_greater (ref_greater_l)
`endif
  );

  assign sig_m = {cmp_clear_m, ser_valid_m, ser_a_m, ser_b_m, ser_last_m, in_ready_m};
  assign sig_l = {cmp_clear_l, ser_valid_l, ser_a_l, ser_b_l, ser_last_l, in_ready_l};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one frame starting in its CLEAR cycle (c=0) through its last bit (c=16).
  // A new pair is offered during cycle 'offer' (none if out of range).
  task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic rdy,
                       input int unsigned offer, input logic [15:0] na, input logic [15:0] nb);
    logic [3:0] i;
    for (int unsigned c = 0; c <= 16; c++) begin
      if (c > 0) tick();
      if (c == 0) begin
        check("clr_m", 16'(sig_m), 16'h0021);
        check("clr_l", 16'(sig_l), 16'h0021);
        cap_ma = '0; cap_mb = '0; cap_la = '0; cap_lb = '0;
      end else begin
        i = 4'(c - 1);
        check($sformatf("bit%0d_m", i), 16'(sig_m),
              16'({1'b0, 1'b1, a[4'd15 - i], b[4'd15 - i], i == 4'd15, rdy}));
        check($sformatf("bit%0d_l", i), 16'(sig_l),
              16'({1'b0, 1'b1, a[i], b[i], i == 4'd15, rdy}));
        cap_ma = {cap_ma[14:0], ser_a_m};
        cap_mb = {cap_mb[14:0], ser_b_m};
        cap_la = {cap_la[14:0], ser_a_l};
        cap_lb = {cap_lb[14:0], ser_b_l};
      end
`ifdef SERIAL_PAIR_SERIALIZER_REF_EN
      check($sformatf("ref%0d_m", c), 16'({ref_less_m, ref_eq_m, ref_greater_m}),
            16'({a < b, a == b, a > b}));
      check($sformatf("ref%0d_l", c), 16'({ref_less_l, ref_eq_l, ref_greater_l}),
            16'({a < b, a == b, a > b}));
`endif
      if (c == offer) begin
        in_valid = 1'b1;
        a_word   = na;
        b_word   = nb;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_m", 16'(sig_m), 16'h0001);
    check("rst_l", 16'(sig_l), 16'h0001);
`ifdef SERIAL_PAIR_SERIALIZER_REF_EN
    check("rst_ref", 16'({ref_less_m, ref_eq_m, ref_greater_m}), 16'h0002);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single frame, both bit orders
    in_valid = 1'b1; a_word = 16'h6482; b_word = 16'h6262;
    tick();
    frame(16'h6482, 16'h6262, 1'b1, 99, '0, '0);
    tick();
    check("t1_idle_m", 16'(sig_m), 16'h0001);
    check("t1_idle_l", 16'(sig_l), 16'h0001);
    check("t1_cap_ma", cap_ma, 16'h6482);
    check("t1_cap_mb", cap_mb, 16'h6262);
    check("t1_cap_la", cap_la, 16'h4126);
    check("t1_cap_lb", cap_lb, 16'h4646);
    check("t1_greater", 16'(cap_ma > cap_mb), 16'h0001);

    // Back to back through the hold buffer
    in_valid = 1'b1; a_word = 16'h0001; b_word = 16'h0002;
    tick();
    frame(16'h0001, 16'h0002, 1'b0, 0, 16'hFFFF, 16'hFFFF);
    tick();
    frame(16'hFFFF, 16'hFFFF, 1'b1, 99, '0, '0);
    check("t3_cap_ma", cap_ma, 16'hFFFF);
    check("t3_cap_mb", cap_mb, 16'hFFFF);
    tick();
    check("t3_idle_m", 16'(sig_m), 16'h0001);

    // Offer exactly on ser_last with an empty hold: direct load, no IDLE gap
    in_valid = 1'b1; a_word = 16'h0010; b_word = 16'h0100;
    tick();
    frame(16'h0010, 16'h0100, 1'b1, 16, 16'h1234, 16'h1234);
    tick();
    frame(16'h1234, 16'h1234, 1'b1, 99, '0, '0);
    tick();
    check("t4_idle_m", 16'(sig_m), 16'h0001);
    check("t4_idle_l", 16'(sig_l), 16'h0001);

    // Reset mid-frame with a held pair pending
    in_valid = 1'b1; a_word = 16'hAAAA; b_word = 16'h5555;
    tick();
    a_word = 16'h0F0F; b_word = 16'hF0F0;
    tick();
    in_valid = 1'b0;
    check("t5_hold_full", 16'(in_ready_m), 16'h0000);
    for (int unsigned k = 0; k < 7; k++) tick();
    check("t5_bit7_valid", 16'(ser_valid_m), 16'h0001);
    rst_n = 1'b0;
    #1;
    check("t5_async_m", 16'(sig_m), 16'h0001);
    check("t5_async_l", 16'(sig_l), 16'h0001);
`ifdef SERIAL_PAIR_SERIALIZER_REF_EN
    check("t5_async_ref", 16'({ref_less_m, ref_eq_m, ref_greater_m}), 16'h0002);
`endif
    tick();
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 20; k++) begin
      tick();
      check($sformatf("t5_quiet%0d", k), 16'(sig_m), 16'h0001);
    end

    // Recovery after reset
    in_valid = 1'b1; a_word = 16'h6482; b_word = 16'h6262;
    tick();
    frame(16'h6482, 16'h6262, 1'b1, 99, '0, '0);
    tick();
    check("t6_idle_m", 16'(sig_m), 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
